// File: rtl/execute_stage.sv
// -----------------------------------------------------------------------------
// execute_stage
//   Execute stage behind the decode/execute pipeline register. Computes a
//   single-cycle ALU result with N/Z/C/V flags, or runs an iterative shift-add
//   multiply that takes WIDTH steps. The result, store data and control bits are
//   registered into the execute/memory boundary. While a multiply is in flight,
//   the stage holds the upstream register with stall.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   flush      : synchronous kill of the in-flight op and the output slot
//   valid_in   : inputs carry a real instruction
//   *_in       : control bits wbs/wme/mm/wm/am/ni, ALUop_in, srcA_in, srcB_in
//   stall      : upstream must hold its register contents (combinational)
//   valid_out  : output slot holds a real result
//   *_out      : registered control pass-through, alu_result, srcB_out
//   flag_n/z/c/v : registered flags of alu_result
// -----------------------------------------------------------------------------
module execute_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             valid_in,
    input  logic             wbs_in,
    input  logic             wme_in,
    input  logic             mm_in,
    input  logic             wm_in,
    input  logic             am_in,
    input  logic             ni_in,
    input  logic [2:0]       ALUop_in,
    input  logic [WIDTH-1:0] srcA_in,
    input  logic [WIDTH-1:0] srcB_in,
    output logic             stall,
    output logic             valid_out,
    output logic             wbs_out,
    output logic             wme_out,
    output logic             mm_out,
    output logic             wm_out,
    output logic             am_out,
    output logic             ni_out,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] srcB_out,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);
    localparam logic [2:0] OP_MUL = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [CW-1:0]     r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]  r_a, w_a_nxt;
    logic [WIDTH-1:0]  r_b, w_b_nxt;
    logic [WIDTH-1:0]  r_acc, w_acc_nxt;

    logic              r_valid;
    logic [5:0]        r_ctrl;
    logic [WIDTH-1:0]  r_res;
    logic [WIDTH-1:0]  r_srcb;
    logic [3:0]        r_nzcv;

    logic              w_stall;
    logic              w_wr_res;
    logic [WIDTH-1:0]  w_res;
    logic [3:0]        w_nzcv;
    logic              w_mul_req;
    logic [WIDTH:0]    w_sum;
    logic [WIDTH:0]    w_dif;
    logic [WIDTH-1:0]  w_alu_res;
    logic              w_alu_c;
    logic              w_alu_v;
    logic [WIDTH-1:0]  w_part;

    assign w_mul_req = valid_in & (ALUop_in == OP_MUL);
    assign w_sum     = {1'b0, srcA_in} + {1'b0, srcB_in};
    assign w_dif     = {1'b0, srcA_in} - {1'b0, srcB_in};
    // One shift-add step: add A shifted by the current bit position when that bit of B is set.
    assign w_part    = r_b[r_cnt] ? (r_a << r_cnt) : '0;

    // Single-cycle ALU datapath with carry and overflow for add/sub.
    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (ALUop_in)
            3'b000: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
                w_alu_v   = (srcA_in[WIDTH-1] == srcB_in[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != srcA_in[WIDTH-1]);
            end
            3'b001: begin
                w_alu_res = w_dif[WIDTH-1:0];
                // Carry means no borrow, i.e. A >= B unsigned.
                w_alu_c   = ~w_dif[WIDTH];
                w_alu_v   = (srcA_in[WIDTH-1] != srcB_in[WIDTH-1]) &&
                            (w_dif[WIDTH-1] != srcA_in[WIDTH-1]);
            end
            3'b010:  w_alu_res = srcA_in & srcB_in;
            3'b011:  w_alu_res = srcA_in | srcB_in;
            3'b100:  w_alu_res = srcA_in ^ srcB_in;
            3'b101:  w_alu_res = srcA_in << srcB_in[3:0];
            3'b111:  w_alu_res = srcA_in >> srcB_in[3:0];
            default: w_alu_res = '0;
        endcase
    end

    // FSM next-state, multiply datapath and output-slot selection.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_acc_nxt   = r_acc;
        w_stall     = 1'b0;
        w_wr_res    = 1'b0;
        w_res       = w_alu_res;
        w_nzcv      = {w_alu_res[WIDTH-1], (w_alu_res == '0), w_alu_c, w_alu_v};
        case (r_state)
            S_IDLE: begin
                if (w_mul_req) begin
                    w_stall     = 1'b1;
                    w_state_nxt = S_BUSY;
                    w_a_nxt     = srcA_in;
                    w_b_nxt     = srcB_in;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                end else begin
                    w_wr_res = valid_in;
                end
            end
            S_BUSY: begin
                w_stall   = 1'b1;
                w_acc_nxt = r_acc + w_part;
                w_cnt_nxt = r_cnt + CW'(1);
                if (r_cnt == LAST_STEP) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_BUSY;
                end
            end
            S_DONE: begin
                // Upstream still holds the multiply; it advances on this edge.
                w_wr_res    = 1'b1;
                w_res       = r_acc;
                w_nzcv      = {r_acc[WIDTH-1], (r_acc == '0), 1'b0, 1'b0};
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        // Flush overrides everything: discard the multiply and bubble the slot.
        if (flush) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_wr_res    = 1'b0;
        end else begin
            w_wr_res = w_wr_res;
        end
    end

    // State, multiply registers and the execute/memory output slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_valid <= 1'b0;
            r_ctrl  <= 6'b000000;
            r_res   <= '0;
            r_srcb  <= '0;
            r_nzcv  <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_acc   <= w_acc_nxt;
            if (w_wr_res) begin
                r_valid <= 1'b1;
                r_ctrl  <= {wbs_in, wme_in, mm_in, wm_in, am_in, ni_in};
                r_res   <= w_res;
                r_srcb  <= srcB_in;
                r_nzcv  <= w_nzcv;
            end else begin
                // Bubble: data and flags hold, valid and controls drop.
                r_valid <= 1'b0;
                r_ctrl  <= 6'b000000;
            end
        end
    end

    assign stall      = rst & w_stall;
    assign valid_out  = r_valid;
    assign {wbs_out, wme_out, mm_out, wm_out, am_out, ni_out} = r_ctrl;
    assign alu_result = r_res;
    assign srcB_out   = r_srcb;
    assign {flag_n, flag_z, flag_c, flag_v} = r_nzcv;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         flush;
    logic         valid_in;
    logic         wbs_in, wme_in, mm_in, wm_in, am_in, ni_in;
    logic [2:0]   ALUop_in;
    logic [W-1:0] srcA_in, srcB_in;
    logic         stall, valid_out;
    logic         wbs_out, wme_out, mm_out, wm_out, am_out, ni_out;
    logic [W-1:0] alu_result, srcB_out;
    logic         flag_n, flag_z, flag_c, flag_v;

    execute_stage #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in),
        .wbs_in(wbs_in), .wme_in(wme_in), .mm_in(mm_in), .wm_in(wm_in),
        .am_in(am_in), .ni_in(ni_in), .ALUop_in(ALUop_in),
        .srcA_in(srcA_in), .srcB_in(srcB_in), .stall(stall),
        .valid_out(valid_out), .wbs_out(wbs_out), .wme_out(wme_out),
        .mm_out(mm_out), .wm_out(wm_out), .am_out(am_out), .ni_out(ni_out),
        .alu_result(alu_result), .srcB_out(srcB_out),
        .flag_n(flag_n), .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [5:0]  ctrl;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        ev;
        logic [5:0]  ectrl;
        logic [15:0] eres;
        logic [3:0]  eflg;   // {n,z,c,v}
        logic [15:0] esrcb;
    } vec_t;

    typedef struct {
        string       name;
        logic        ev;
        logic [5:0]  ectrl;
        logic [15:0] eres;
        logic [3:0]  eflg;
        logic [15:0] esrcb;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[16];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc;
    int   stall_cnt;

    task automatic drive(input logic v, input logic [5:0] c, input logic [2:0] o,
                         input logic [15:0] aa, input logic [15:0] bb);
        valid_in = v;
        {wbs_in, wme_in, mm_in, wm_in, am_in, ni_in} = c;
        ALUop_in = o;
        srcA_in  = aa;
        srcB_in  = bb;
    endtask

    task automatic push(input string nm, input logic ev, input logic [5:0] ec,
                        input logic [15:0] er, input logic [3:0] ef, input logic [15:0] eb);
        exp_t e;
        e.name = nm; e.ev = ev; e.ectrl = ec; e.eres = er; e.eflg = ef; e.esrcb = eb;
        sbq.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        logic [5:0] ac;
        logic [3:0] af;
        n_vec++;
        if (sbq.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: output observed with no expected entry");
        end else begin
            e  = sbq.pop_front();
            ac = {wbs_out, wme_out, mm_out, wm_out, am_out, ni_out};
            af = {flag_n, flag_z, flag_c, flag_v};
            if (valid_out !== e.ev || ac !== e.ectrl || alu_result !== e.eres ||
                af !== e.eflg || srcB_out !== e.esrcb) begin
                n_err++;
                $display("FAIL %s: got v=%b ctrl=%b res=%h nzcv=%b srcb=%h, want v=%b ctrl=%b res=%h nzcv=%b srcb=%h",
                         e.name, valid_out, ac, alu_result, af, srcB_out,
                         e.ev, e.ectrl, e.eres, e.eflg, e.esrcb);
            end
        end
    endtask

    task automatic check1(input string nm, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, act, want);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            v  ctrl       op      A         B         ev ectrl      eres      nzcv     esrcb
        tbl[0]  = '{1'b1, 6'b101000, 3'b000, 16'h0002, 16'h0003, 1'b1, 6'b101000, 16'h0005, 4'b0000, 16'h0003};
        tbl[1]  = '{1'b1, 6'b010101, 3'b001, 16'h0006, 16'h0007, 1'b1, 6'b010101, 16'hFFFF, 4'b1000, 16'h0007};
        tbl[2]  = '{1'b1, 6'b000010, 3'b000, 16'h7FFF, 16'h0001, 1'b1, 6'b000010, 16'h8000, 4'b1001, 16'h0001};
        tbl[3]  = '{1'b1, 6'b000001, 3'b000, 16'hFFFF, 16'h0001, 1'b1, 6'b000001, 16'h0000, 4'b0110, 16'h0001};
        tbl[4]  = '{1'b1, 6'b110000, 3'b001, 16'h0005, 16'h0005, 1'b1, 6'b110000, 16'h0000, 4'b0110, 16'h0005};
        tbl[5]  = '{1'b1, 6'b001100, 3'b001, 16'h8000, 16'h0001, 1'b1, 6'b001100, 16'h7FFF, 4'b0011, 16'h0001};
        tbl[6]  = '{1'b1, 6'b100001, 3'b010, 16'h00F0, 16'h0FF0, 1'b1, 6'b100001, 16'h00F0, 4'b0000, 16'h0FF0};
        tbl[7]  = '{1'b1, 6'b011000, 3'b011, 16'h0001, 16'h0002, 1'b1, 6'b011000, 16'h0003, 4'b0000, 16'h0002};
        tbl[8]  = '{1'b1, 6'b000100, 3'b100, 16'hFFFF, 16'h0F0F, 1'b1, 6'b000100, 16'hF0F0, 4'b1000, 16'h0F0F};
        tbl[9]  = '{1'b1, 6'b100000, 3'b101, 16'h0001, 16'h000F, 1'b1, 6'b100000, 16'h8000, 4'b1000, 16'h000F};
        tbl[10] = '{1'b1, 6'b010000, 3'b111, 16'h8000, 16'h0004, 1'b1, 6'b010000, 16'h0800, 4'b0000, 16'h0004};
        tbl[11] = '{1'b1, 6'b001000, 3'b101, 16'h1234, 16'h0010, 1'b1, 6'b001000, 16'h1234, 4'b0000, 16'h0010};
        tbl[12] = '{1'b0, 6'b111111, 3'b000, 16'hFFFF, 16'hFFFF, 1'b0, 6'b000000, 16'h1234, 4'b0000, 16'h0010};
        tbl[13] = '{1'b1, 6'b000010, 3'b111, 16'h8000, 16'h0004, 1'b1, 6'b000010, 16'h0800, 4'b0000, 16'h0004};
        tbl[14] = '{1'b0, 6'b111111, 3'b110, 16'h1111, 16'h2222, 1'b0, 6'b000000, 16'h0800, 4'b0000, 16'h0004};
        tbl[15] = '{1'b1, 6'b000000, 3'b001, 16'h0000, 16'h0001, 1'b1, 6'b000000, 16'hFFFF, 4'b1000, 16'h0001};

        // Reset state, with a multiply presented to show stall stays low.
        rst   = 1'b0;
        flush = 1'b0;
        drive(1'b1, 6'b111111, 3'b110, 16'h1234, 16'h5678);
        #3;
        push("reset_state", 1'b0, 6'b000000, 16'h0000, 4'b0000, 16'h0000);
        check_out();
        check1("reset_stall", int'(stall), 0);
        #4;
        drive(1'b0, 6'b000000, 3'b000, 16'h0000, 16'h0000);
        rst = 1'b1;

        // Table-driven single-cycle ops and bubbles.
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].v, tbl[i].ctrl, tbl[i].op, tbl[i].a, tbl[i].b);
            #1;
            check1($sformatf("vec%0d_stall", i), int'(stall), 0);
            push($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ectrl, tbl[i].eres, tbl[i].eflg, tbl[i].esrcb);
            @(posedge clk);
            #1;
            check_out();
        end

        // Multiply 6*7: stall cycles 0..16, result appears in cycle 18.
        drive(1'b1, 6'b100010, 3'b110, 16'h0006, 16'h0007);
        #1;
        check1("mul_stall_c0", int'(stall), 1);
        push("mul_6x7", 1'b1, 6'b100010, 16'h002A, 4'b0000, 16'h0007);
        stall_cnt = (stall === 1'b1) ? 1 : 0;
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (valid_out === 1'b1) break;
            if (stall === 1'b1) stall_cnt++;
        end
        drive(1'b1, 6'b000001, 3'b000, 16'h0010, 16'h0020);
        check1("mul_latency", cyc, 18);
        check1("mul_stall_cycles", stall_cnt, 17);
        check_out();
        #1;
        check1("post_mul_stall", int'(stall), 0);
        push("post_mul_add", 1'b1, 6'b000001, 16'h0030, 4'b0000, 16'h0020);
        @(posedge clk);
        #1;
        check_out();

        // Flush in cycle 5 of a multiply.
        drive(1'b1, 6'b111111, 3'b110, 16'h0003, 16'h0005);
        #1;
        check1("flushmul_stall_c0", int'(stall), 1);
        repeat (5) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        drive(1'b1, 6'b010000, 3'b011, 16'h0001, 16'h0002);
        check1("flush_valid_out", int'(valid_out), 0);
        #1;
        check1("flush_stall", int'(stall), 0);
        push("post_flush_or", 1'b1, 6'b010000, 16'h0003, 4'b0000, 16'h0002);
        @(posedge clk);
        #1;
        check_out();
        drive(1'b0, 6'b000000, 3'b000, 16'h0000, 16'h0000);
        push("post_flush_idle", 1'b0, 6'b000000, 16'h0003, 4'b0000, 16'h0002);
        @(posedge clk);
        #1;
        check_out();

        // Asynchronous reset in cycle 8 of a multiply.
        drive(1'b1, 6'b111111, 3'b110, 16'h0009, 16'h0009);
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        push("async_reset", 1'b0, 6'b000000, 16'h0000, 4'b0000, 16'h0000);
        check_out();
        check1("async_reset_stall", int'(stall), 0);
        drive(1'b1, 6'b000100, 3'b010, 16'h00F0, 16'h0FF0);
        #1;
        rst = 1'b1;
        #1;
        check1("post_reset_stall", int'(stall), 0);
        push("post_reset_and", 1'b1, 6'b000100, 16'h00F0, 4'b0000, 16'h0FF0);
        @(posedge clk);
        #1;
        check_out();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Execute stage that consumes the outputs of the decode/execute pipeline register: control bits wbs, wme, mm, wm, am, ni, the 3-bit ALUop and the 16-bit operands srcA/srcB.
- Computes the ALU result and flags, including a multi-cycle iterative multiply.
- Registers the result plus pass-through control into the execute/memory boundary.
- Drives a stall back to the decode/execute register while a multiply is in progress.

Parameters:
WIDTH, 16, operand/result width; also the number of multiply iterations.

Ports:
clk  input  1  clock; all flops on rising edge
rst  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of in-flight op and output slot
valid_in  input  1  srcA/srcB/ALUop/control hold a real instruction
wbs_in, wme_in, mm_in, wm_in, am_in, ni_in  input  1 each  control bits from decode/execute register
ALUop_in  input  3  operation select
srcA_in  input  WIDTH  operand A
srcB_in  input  WIDTH  operand B / store data
stall  output  1  upstream must hold its register contents
valid_out  output  1  output slot holds a real result
wbs_out, wme_out, mm_out, wm_out, am_out, ni_out  output  1 each  registered control pass-through
alu_result  output  WIDTH  registered result
srcB_out  output  WIDTH  registered srcB (store data)
flag_n, flag_z, flag_c, flag_v  output  1 each  registered flags of alu_result

Behaviour:

Reset (rst=0, asynchronous):
- All outputs 0.
- FSM to IDLE; iteration counter 0.
- Reset mid-multiply aborts the multiply.
- stall=0 while reset is asserted.

ALUop encoding:
- 000 add
- 001 sub (A-B)
- 010 and
- 011 or
- 100 xor
- 101 shl A by B[3:0]
- 110 mul (low WIDTH bits of A*B)
- 111 shr logical A by B[3:0]

Single-cycle ops (not 110):
- Latency 1: inputs sampled at edge E, outputs valid after E.
- No stall.
- Back-to-back issue every cycle.

Flags:
- Z = (result==0); N = result[WIDTH-1].
- add: C = carry out; V = signed overflow.
- sub: C = 1 when A>=B unsigned (no borrow); V = signed overflow.
- All other ops: C=0, V=0.

FSM states IDLE, BUSY, DONE:
- IDLE:
  - stall = valid_in & (ALUop_in==110), combinational.
  - On an edge with that condition: latch A, B; acc=0; cnt=0; go to BUSY; output slot becomes a bubble.
- BUSY:
  - stall=1.
  - Each edge performs one shift-add step: acc += B[cnt] ? (A<<cnt) : 0; cnt++.
  - On the edge where cnt==WIDTH-1, go to DONE.
  - Output slot is a bubble every BUSY edge.
- DONE:
  - stall=0.
  - Next edge writes acc to alu_result with valid_out=1, control bits from current inputs, flags Z/N (C=V=0); go to IDLE.
  - Upstream advances on the same edge.
- Multiply timing with mul presented in cycle 0:
  - stall high cycles 0..WIDTH (WIDTH+1 cycles).
  - Result visible from cycle WIDTH+2.

Bubble:
- Caused by valid_in=0, flush, or a BUSY/IDLE-start edge.
- valid_out=0 and all six control outs=0.
- alu_result, srcB_out and flags hold their previous values.

Flush:
- Highest priority on an edge.
- Output slot becomes a bubble; FSM to IDLE; cnt cleared; multiply discarded.
- stall=0 in the following cycle unless a new mul is presented.

Other rules:
- Simultaneous valid_in=0 and ALUop_in=110: no multiply starts.
- Inputs during BUSY are ignored; upstream holds them stable under stall.
- Arithmetic wraps modulo 2^WIDTH.
- Shift amounts 0..15; a shift of 0 passes A unchanged.

Test Plan:
1. add: srcA=0x0002, srcB=0x0003, ALUop=000, valid_in=1, wbs=1, mm=1 -> next cycle alu_result=0x0005, valid_out=1, wbs_out=1, mm_out=1, wme_out=0, Z=N=C=V=0, stall=0.
2. sub/overflow: 6-7 -> 0xFFFF, N=1, C=0; then 0x7FFF+0x0001 -> 0x8000, N=1, V=1, C=0; then 0xFFFF+1 -> 0x0000, Z=1, C=1.
3. mul: A=6, B=7, ALUop=110 in cycle 0 -> stall=1 cycles 0..16, valid_out=0 cycles 1..17, alu_result=0x002A with valid_out=1 in cycle 18; following add issues with no extra stall.
4. flush at cycle 5 of a multiply -> valid_out=0 next cycle, stall=0 next cycle; subsequent 1 or 2 -> 0x0003 one cycle later.
5. rst=0 asynchronously mid-multiply (cycle 8) -> all outputs 0 and stall=0 immediately; after release, an and of 0x00F0&0x0FF0 -> 0x00F0.
6. shifts/bubble: shl 0x0001 by 15 -> 0x8000, N=1; shr 0x8000 by 4 -> 0x0800; valid_in=0 -> valid_out=0, controls 0, alu_result held at 0x0800.
